// File: rtl/expr_pkg.sv
// Shared types and constants for the expression transmitter.
package expr_pkg;

    localparam int MAX_N_DEF = 8;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] PLUS = 8'h2B;
    localparam logic [7:0] STAR = 8'h2A;

    typedef enum logic [1:0] {
        IDLE,
        SEND_D,
        SEND_OP
    } state_t;

endpackage

// File: rtl/ascii_enc.sv
// Combinational mapping of a digit or operator selection to its ASCII character.
module ascii_enc
    import expr_pkg::*;
(
    input  logic       is_op,
    input  logic       op_bit,
    input  logic [3:0] digit,
    output logic [7:0] ch
);

    always_comb begin
        if (is_op) begin
            ch = op_bit ? STAR : PLUS;
        end else begin
            ch = ZERO + {4'b0000, digit};
        end
    end

endmodule

// File: rtl/expr_tx.sv
// Streams a captured BCD expression as ASCII characters over a valid/ready handshake.
module expr_tx
    import expr_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [3:0]         len,
    input  logic [4*MAX_N-1:0] digits,
    input  logic [MAX_N-2:0]   ops,
    input  logic               ready,
    output logic [7:0]         out,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         len_q;
    logic [4*MAX_N-1:0] digits_q;
    logic [MAX_N-2:0]   ops_q;
    logic               done_d, err_d, capture;
    logic               bad_req, last_idx;
    logic [3:0]         cur_digit;
    logic               cur_op;
    logic [7:0]         ch;

    // Only operands that will actually be sent are range-checked.
    always_comb begin
        bad_req = (len == 4'd0) || (32'(len) > MAX_N);
        for (int i = 0; i < MAX_N; i++) begin
            if ((32'(len) > i) && (digits[4*i +: 4] > 4'd9)) begin
                bad_req = 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_op    = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = digits_q[4*i +: 4];
            end
        end
        for (int i = 0; i < MAX_N - 1; i++) begin
            if (idx_q == IW'(i)) begin
                cur_op = ops_q[i];
            end
        end
    end

    assign last_idx = (idx_q == IW'(len_q - 4'd1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        idx_d   = '0;
                        state_d = SEND_D;
                    end
                end
            end
            SEND_D: begin
                if (ready) begin
                    if (last_idx) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND_OP;
                    end
                end
            end
            SEND_OP: begin
                if (ready) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SEND_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            len_q    <= 4'd0;
            digits_q <= '0;
            ops_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done    <= done_d;
            err     <= err_d;
            if (capture) begin
                len_q    <= len;
                digits_q <= digits;
                ops_q    <= ops;
            end
        end
    end

    ascii_enc u_enc (
        .is_op  (state_q == SEND_OP),
        .op_bit (cur_op),
        .digit  (cur_digit),
        .ch     (ch)
    );

    assign valid = (state_q != IDLE);
    assign busy  = (state_q != IDLE);
    assign out   = valid ? ch : 8'h00;

endmodule

// File: tb/tb_expr_tx.sv
// Directed self-checking bench for expr_tx.
module tb_expr_tx;

    localparam int MAX_N = 8;

    logic               clk = 1'b0;
    logic               clr, start, ready;
    logic [3:0]         len;
    logic [4*MAX_N-1:0] digits;
    logic [MAX_N-2:0]   ops;
    logic [7:0]         out;
    logic               valid, busy, done, err;

    int checks = 0;
    int errors = 0;

    expr_tx #(.MAX_N(MAX_N)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .len    (len),
        .digits (digits),
        .ops    (ops),
        .ready  (ready),
        .out    (out),
        .valid  (valid),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Character present and held for this cycle, then one clock.
    task automatic expect_char(input string tag, input logic [7:0] c);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(c));
        chk({tag, "_done"}, 32'(done), 32'd0);
        step();
    endtask

    task automatic expect_idle(input string tag, input logic exp_done, input logic exp_err);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out"}, 32'(out), 32'h00);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; ready = 1'b1;
        len = 4'd0; digits = '0; ops = '0;
        step();
        step();
        clr = 1'b0;
        expect_idle("reset", 1'b0, 1'b0);

        // "1+2*3", ready always high; inputs scrambled after capture
        len = 4'd3; digits = 32'h0000_0321; ops = 7'b0000010; start = 1'b1;
        step();
        start = 1'b0; len = 4'd5; digits = 32'h9999_9999; ops = 7'h7F;
        expect_char("t1_d0", 8'h31);
        expect_char("t1_op0", 8'h2B);
        expect_char("t1_d1", 8'h32);
        expect_char("t1_op1", 8'h2A);
        expect_char("t1_d2", 8'h33);
        expect_idle("t1_done", 1'b1, 1'b0);
        step();
        expect_idle("t1_after", 1'b0, 1'b0);

        // Same request, stall 3 cycles on "+"
        len = 4'd3; digits = 32'h0000_0321; ops = 7'b0000010; start = 1'b1;
        step();
        start = 1'b0;
        expect_char("t2_d0", 8'h31);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) expect_char("t2_stall", 8'h2B);
        ready = 1'b1;
        expect_char("t2_op0", 8'h2B);
        expect_char("t2_d1", 8'h32);
        expect_char("t2_op1", 8'h2A);
        expect_char("t2_d2", 8'h33);
        expect_idle("t2_done", 1'b1, 1'b0);
        step();

        // Single operand 7
        len = 4'd1; digits = 32'h0000_0007; ops = '0; start = 1'b1;
        step();
        start = 1'b0;
        expect_char("t3_d0", 8'h37);
        expect_idle("t3_done", 1'b1, 1'b0);
        step();

        // Unused operand above 9 is not a fault
        len = 4'd1; digits = 32'h0000_00A3; start = 1'b1;
        step();
        start = 1'b0;
        expect_char("t3b_d0", 8'h33);
        expect_idle("t3b_done", 1'b1, 1'b0);
        step();

        // Rejections: operand1=10, len=0, len=9
        len = 4'd2; digits = 32'h0000_00A5; start = 1'b1;
        step();
        start = 1'b0;
        expect_idle("t4_bcd_err", 1'b0, 1'b1);
        step();
        expect_idle("t4_bcd_after", 1'b0, 1'b0);
        len = 4'd0; digits = 32'h0000_0011; start = 1'b1;
        step();
        start = 1'b0;
        expect_idle("t4_len0_err", 1'b0, 1'b1);
        step();
        expect_idle("t4_len0_after", 1'b0, 1'b0);
        len = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        expect_idle("t4_len9_err", 1'b0, 1'b1);
        step();

        // Max length: "12345678" with all '*' operators, index reaches 7
        len = 4'd8; digits = 32'h8765_4321; ops = 7'h7F; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            expect_char("t4b_d", 8'(8'h31 + i));
            expect_char("t4b_op", 8'h2A);
        end
        expect_char("t4b_dlast", 8'h38);
        expect_idle("t4b_done", 1'b1, 1'b0);
        step();

        // clr while second character is shown, with start also high
        len = 4'd3; digits = 32'h0000_0321; ops = 7'b0000010; start = 1'b1;
        step();
        start = 1'b0;
        expect_char("t5_d0", 8'h31);
        chk("t5_op0_out", 32'(out), 32'h2B);
        clr = 1'b1; start = 1'b1;
        step();
        clr = 1'b0; start = 1'b0;
        expect_idle("t5_clr", 1'b0, 1'b0);
        step();
        expect_idle("t5_nodone", 1'b0, 1'b0);
        len = 4'd1; digits = 32'h0000_0005; start = 1'b1;
        step();
        start = 1'b0;
        expect_char("t5_new", 8'h35);
        expect_idle("t5_new_done", 1'b1, 1'b0);
        step();

        // start held high: ignored while busy, restarts in the done cycle
        len = 4'd2; digits = 32'h0000_0021; ops = '0; start = 1'b1;
        step();
        expect_char("t6a_d0", 8'h31);
        expect_char("t6a_op0", 8'h2B);
        expect_char("t6a_d1", 8'h32);
        expect_idle("t6_gap", 1'b1, 1'b0);
        step();
        start = 1'b0;
        expect_char("t6b_d0", 8'h31);
        expect_char("t6b_op0", 8'h2B);
        expect_char("t6b_d1", 8'h32);
        expect_idle("t6b_done", 1'b1, 1'b0);
        step();
        expect_idle("t6_end", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 SHALL have parameter MAX_N, default 8, meaning the maximum operand count per expression.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to send one expression; sampled only in IDLE.
REQ-005 SHALL have port len, input, 4, operand count n (valid 1..MAX_N).
REQ-006 SHALL have port digits, input, 4*MAX_N, packed BCD operands; operand i = digits[4i+3:4i].
REQ-007 SHALL have port ops, input, MAX_N-1, operators; ops[i]=0 is '+', 1 is '*', placed between operand i and operand i+1.
REQ-008 SHALL have port ready, input, 1, consumer accepts the current character this cycle.
REQ-009 SHALL have port out, output, 8, current ASCII character.
REQ-010 SHALL have port valid, output, 1, out holds a character.
REQ-011 SHALL have port busy, output, 1, an expression is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last character is accepted.
REQ-013 SHALL have port err, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL implement an FSM with states IDLE, SEND_D, SEND_OP.
REQ-015 SHALL, in IDLE with start=1, capture len, digits and ops into internal registers; later changes to these inputs SHALL have no effect.
REQ-016 SHALL reject a request with len=0, len>MAX_N, or any used operand (i<len) >9: err=1 for the following cycle, state stays IDLE, valid stays 0.
REQ-017 SHALL, on an accepted request, enter SEND_D with valid=1, busy=1 in the next cycle (latency 1).
REQ-018 SHALL emit in order D0, OP0, D1, ..., D(n-1), i.e. 2n-1 characters, with no trailing operator.
REQ-019 SHALL encode a digit d as 8'h30+d, '+' as 8'h2B, '*' as 8'h2A.
REQ-020 SHALL advance one character only on a cycle with valid=1 and ready=1.
REQ-021 SHALL hold out and valid stable while valid=1 and ready=0 (arbitrary stall length).
REQ-022 SHALL transition SEND_D->SEND_OP on handshake when operand index <n-1, and SEND_OP->SEND_D on handshake with index incremented.
REQ-023 SHALL, on handshake of D(n-1), return to IDLE with valid=0, busy=0 and done=1 in the next cycle.
REQ-024 SHALL accept a start asserted in the cycle where done=1, since the FSM is then in IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL drive out=8'h00 whenever valid=0.
REQ-027 SHALL use a $clog2(MAX_N)-bit operand index that never wraps; it resets to 0 on each accepted request.

Reset
REQ-028 SHALL, on clr=1 at a clock edge, force IDLE, out=8'h00, valid=0, busy=0, done=0, err=0 and index=0.
REQ-029 SHALL abort an in-progress expression on clr with no done pulse; clr SHALL take priority over start and ready.

Structure
REQ-030 SHALL place the FSM state enum, ASCII constants (ZERO=8'h30, PLUS=8'h2B, STAR=8'h2A) and MAX_N default in package expr_pkg.
REQ-031 SHALL use one combinational sub-module, ascii_enc, that maps {is_op, op_bit, digit} to the 8-bit character.

Verification
REQ-032 SHALL cover: len=3, digits {1,2,3}, ops {0,1}, ready=1 -> out "1","+","2","*","3" on 5 consecutive cycles beginning 1 cycle after start; done pulse in the following cycle.
REQ-033 SHALL cover: same request, ready=0 for 3 cycles while "+" is shown -> "+" held for 4 cycles, then the sequence continues unchanged.
REQ-034 SHALL cover: len=1, digit 7 -> single "7" (8'h37), done next cycle, no operator emitted.
REQ-035 SHALL cover: len=2, operand1=10, and separately len=0 -> err one cycle, valid never asserted.
REQ-036 SHALL cover: clr during the second character -> all outputs at reset values in the next cycle, no done; a new start is then accepted normally.
REQ-037 SHALL cover: start held high throughout -> ignored while busy; a second expression starts in the done cycle, giving one idle cycle between the two streams.
